// File: rtl/cva6_shared_tlb_mp.sv
// cva6_shared_tlb_mp: multi-port set-associative shared L2 TLB with round-robin lookups, PTW fills
// and global/VPN/ASID flushes. Define SHARED_TLB_PERF_EN to get the hit/miss counters.
module cva6_shared_tlb_mp #(
    parameter int NR_PORTS = 2,
    parameter int DEPTH    = 64,
    parameter int WAYS     = 2,
    parameter int VPN_W    = 27,
    parameter int PPN_W    = 44,
    parameter int ASID_W   = 16,
    parameter int PERM_W   = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [NR_PORTS-1:0]        req_valid_i,
    output logic [NR_PORTS-1:0]        req_ready_o,
    input  logic [NR_PORTS*VPN_W-1:0]  req_vpn_i,
    input  logic [NR_PORTS*ASID_W-1:0] req_asid_i,
    output logic [NR_PORTS-1:0]        resp_valid_o,
    output logic                       resp_hit_o,
    output logic [PPN_W-1:0]           resp_ppn_o,
    output logic [PERM_W-1:0]          resp_perm_o,
    input  logic                       fill_valid_i,
    input  logic [VPN_W-1:0]           fill_vpn_i,
    input  logic [ASID_W-1:0]          fill_asid_i,
    input  logic [PPN_W-1:0]           fill_ppn_i,
    input  logic [PERM_W-1:0]          fill_perm_i,
    input  logic                       flush_i,
    input  logic                       flush_vpn_valid_i,
    input  logic                       flush_asid_valid_i,
    input  logic [VPN_W-1:0]           flush_vpn_i,
    input  logic [ASID_W-1:0]          flush_asid_i,
    output logic                       flush_busy_o,
    output logic [31:0]                hit_cnt_o,
    output logic [31:0]                miss_cnt_o
);
    localparam int SETS   = DEPTH / WAYS;
    localparam int IDX_W  = $clog2(SETS);
    localparam int WAY_W  = WAYS > 1 ? $clog2(WAYS) : 1;
    localparam int PORT_W = NR_PORTS > 1 ? $clog2(NR_PORTS) : 1;
    localparam int G_BIT  = 5;

    typedef enum logic {IDLE, WALK} state_e;

    state_e              r_state, w_state_nxt;
    logic [WAYS-1:0]     r_valid [SETS];
    logic [VPN_W-1:0]    r_vpn   [SETS][WAYS];
    logic [ASID_W-1:0]   r_asid  [SETS][WAYS];
    logic [PPN_W-1:0]    r_ppn   [SETS][WAYS];
    logic [PERM_W-1:0]   r_perm  [SETS][WAYS];
    logic [WAY_W-1:0]    r_vic   [SETS];
    logic [PORT_W-1:0]   r_rr;
    logic [IDX_W-1:0]    r_walk_set;
    logic [ASID_W-1:0]   r_walk_asid;
    logic [NR_PORTS-1:0] r_resp_valid;
    logic                r_resp_hit;
    logic [PPN_W-1:0]    r_resp_ppn;
    logic [PERM_W-1:0]   r_resp_perm;

    logic [2*NR_PORTS-1:0] w_req2;
    logic [PORT_W-1:0]     w_off, w_gnt;
    logic [PORT_W:0]       w_sum;
    logic                  w_any, w_block, w_fill_en, w_evict, w_flush_all;
    logic [VPN_W-1:0]      w_lk_vpn;
    logic [ASID_W-1:0]     w_lk_asid;
    logic [IDX_W-1:0]      w_lk_set, w_fl_set, w_fs_set;
    logic [WAYS-1:0]       w_lk_match, w_fl_match, w_fs_inv, w_walk_inv;
    logic [PPN_W-1:0]      w_lk_ppn;
    logic [PERM_W-1:0]     w_lk_perm;
    logic [WAY_W-1:0]      w_fill_way;

    assign flush_busy_o = r_state == WALK;
    assign w_block      = fill_valid_i | flush_i | flush_busy_o;
    assign w_any        = |req_valid_i && !w_block;
    // Rotate requests so the lowest set bit is the first requester at or after rr.
    assign w_req2       = {req_valid_i, req_valid_i} >> r_rr;
    assign w_sum        = {1'b0, r_rr} + {1'b0, w_off};
    assign w_gnt        = PORT_W'(w_sum >= (PORT_W+1)'(NR_PORTS) ? w_sum - (PORT_W+1)'(NR_PORTS) : w_sum);
    assign req_ready_o  = w_any ? NR_PORTS'(1) << w_gnt : '0;
    assign w_fill_en    = fill_valid_i && !flush_i && !flush_busy_o;
    assign w_flush_all  = flush_i && !flush_vpn_valid_i && !flush_asid_valid_i && !flush_busy_o;
    assign w_lk_set     = w_lk_vpn[IDX_W-1:0];
    assign w_fl_set     = fill_vpn_i[IDX_W-1:0];
    assign w_fs_set     = flush_vpn_i[IDX_W-1:0];

    always_comb begin
        w_off      = '0;
        w_lk_vpn   = '0;
        w_lk_asid  = '0;
        w_lk_match = '0;
        w_fl_match = '0;
        w_fs_inv   = '0;
        w_walk_inv = '0;
        w_lk_ppn   = '0;
        w_lk_perm  = '0;
        w_fill_way = r_vic[w_fl_set];
        w_evict    = 1'b1;
        for (int k = NR_PORTS - 1; k >= 0; k--)
            if (w_req2[k]) w_off = PORT_W'(k);
        for (int k = 0; k < NR_PORTS; k++)
            if (PORT_W'(k) == w_gnt) begin
                w_lk_vpn  = req_vpn_i[k*VPN_W +: VPN_W];
                w_lk_asid = req_asid_i[k*ASID_W +: ASID_W];
            end
        for (int w = 0; w < WAYS; w++) begin
            w_lk_match[w] = r_valid[w_lk_set][w] && r_vpn[w_lk_set][w] == w_lk_vpn &&
                            (r_perm[w_lk_set][w][G_BIT] || r_asid[w_lk_set][w] == w_lk_asid);
            w_fl_match[w] = r_valid[w_fl_set][w] && r_vpn[w_fl_set][w] == fill_vpn_i &&
                            (r_perm[w_fl_set][w][G_BIT] || r_asid[w_fl_set][w] == fill_asid_i);
            w_fs_inv[w]   = r_valid[w_fs_set][w] && r_vpn[w_fs_set][w] == flush_vpn_i &&
                            (!flush_asid_valid_i || (!r_perm[w_fs_set][w][G_BIT] && r_asid[w_fs_set][w] == flush_asid_i));
            w_walk_inv[w] = !r_perm[r_walk_set][w][G_BIT] && r_asid[r_walk_set][w] == r_walk_asid;
            w_lk_ppn      = w_lk_ppn | (w_lk_match[w] ? r_ppn[w_lk_set][w] : '0);
            w_lk_perm     = w_lk_perm | (w_lk_match[w] ? r_perm[w_lk_set][w] : '0);
        end
        // Refill of an existing translation wins over the lowest free way, which wins over the victim.
        for (int w = WAYS - 1; w >= 0; w--)
            if (!r_valid[w_fl_set][w]) begin
                w_fill_way = WAY_W'(w);
                w_evict    = 1'b0;
            end
        for (int w = 0; w < WAYS; w++)
            if (w_fl_match[w]) begin
                w_fill_way = WAY_W'(w);
                w_evict    = 1'b0;
            end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (r_state == IDLE) w_state_nxt = (flush_i && flush_asid_valid_i && !flush_vpn_valid_i) ? WALK : IDLE;
        else w_state_nxt = r_walk_set == IDX_W'(SETS - 1) ? IDLE : WALK;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state      <= IDLE;
            r_walk_set   <= '0;
            r_walk_asid  <= '0;
            r_rr         <= '0;
            r_resp_valid <= '0;
            r_resp_hit   <= 1'b0;
            r_resp_ppn   <= '0;
            r_resp_perm  <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_walk_set   <= flush_busy_o ? r_walk_set + 1'b1 : '0;
            r_resp_valid <= req_ready_o;
            r_resp_hit   <= w_any && |w_lk_match;
            r_resp_ppn   <= w_any ? w_lk_ppn : '0;
            r_resp_perm  <= w_any ? w_lk_perm : '0;
            if (!flush_busy_o && flush_i) r_walk_asid <= flush_asid_i;
            if (w_any) r_rr <= w_gnt == PORT_W'(NR_PORTS - 1) ? '0 : w_gnt + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int s = 0; s < SETS; s++) begin
                r_valid[s] <= '0;
                r_vic[s]   <= '0;
            end
        end else if (flush_busy_o) begin
            r_valid[r_walk_set] <= r_valid[r_walk_set] & ~w_walk_inv;
        end else if (w_flush_all) begin
            for (int s = 0; s < SETS; s++) r_valid[s] <= '0;
        end else if (flush_i && flush_vpn_valid_i) begin
            r_valid[w_fs_set] <= r_valid[w_fs_set] & ~w_fs_inv;
        end else if (w_fill_en) begin
            r_valid[w_fl_set][w_fill_way] <= 1'b1;
            if (w_evict) r_vic[w_fl_set] <= WAYS == 1 ? '0 : r_vic[w_fl_set] + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_fill_en) begin
            r_vpn[w_fl_set][w_fill_way]  <= fill_vpn_i;
            r_asid[w_fl_set][w_fill_way] <= fill_asid_i;
            r_ppn[w_fl_set][w_fill_way]  <= fill_ppn_i;
            r_perm[w_fl_set][w_fill_way] <= fill_perm_i;
        end
    end

`ifdef SHARED_TLB_PERF_EN
    logic [31:0] r_hit_cnt, r_miss_cnt;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else if (w_flush_all) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else if (|r_resp_valid) begin
            if (r_resp_hit) r_hit_cnt <= r_hit_cnt + 1'b1;
            else r_miss_cnt <= r_miss_cnt + 1'b1;
        end
    end
    assign hit_cnt_o  = r_hit_cnt;
    assign miss_cnt_o = r_miss_cnt;
`else
    assign hit_cnt_o  = '0;
    assign miss_cnt_o = '0;
`endif

    assign resp_valid_o = r_resp_valid;
    assign resp_hit_o   = r_resp_hit;
    assign resp_ppn_o   = r_resp_ppn;
    assign resp_perm_o  = r_resp_perm;

    a_single_hit: assert property (@(posedge clk_i) disable iff (!rst_ni) w_any |-> $onehot0(w_lk_match));
endmodule

// File: doc/cva6_shared_tlb_mp.md
# cva6_shared_tlb_mp

Multi-port, set-associative shared second-level TLB for the CVA6 MMU. It sits between NR_PORTS first-level TLBs (ITLB, DTLB, and optional extra requesters such as a vector LSU) and the PTW. It arbitrates lookups round-robin and answers each one in a single cycle. It accepts PTW fills with per-set round-robin replacement and supports global, by-address and by-ASID flushes. It generalises the fixed 2-requester shared TLB in depth, associativity and port count, and adds selective ASID flush.

## Interface
- NR_PORTS, 2: number of lookup requesters (1..8)
- DEPTH, 64: total entries; power of two
- WAYS, 2: associativity; power of two; SETS = DEPTH/WAYS ≥ 2
- VPN_W, 27: virtual page number width (Sv39)
- PPN_W, 44: physical page number width
- ASID_W, 16: address-space ID width
- PERM_W, 8: packed PTE permission/attribute bits (D,A,G,U,X,W,R,V)

- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_valid_i  in  NR_PORTS  lookup request per port
- req_ready_o  out  NR_PORTS  request accepted this cycle
- req_vpn_i  in  NR_PORTS×VPN_W  lookup VPN per port
- req_asid_i  in  NR_PORTS×ASID_W  lookup ASID per port
- resp_valid_o  out  NR_PORTS  response, one cycle after acceptance
- resp_hit_o  out  1  hit flag for the responding port
- resp_ppn_o  out  PPN_W  translated PPN; 0 on miss
- resp_perm_o  out  PERM_W  permission bits; 0 on miss
- fill_valid_i  in  1  PTW fill (4 KiB granule; the PTW splinters superpages)
- fill_vpn_i / fill_asid_i / fill_ppn_i / fill_perm_i  in  VPN_W/ASID_W/PPN_W/PERM_W  fill contents; perm bit 5 = G
- flush_i  in  1  flush request
- flush_vpn_valid_i, flush_asid_valid_i  in  1 each  selective-flush qualifiers
- flush_vpn_i / flush_asid_i  in  VPN_W/ASID_W  flush operands
- flush_busy_o  out  1  ASID walk in progress
- hit_cnt_o, miss_cnt_o  out  32 each  performance counters

## Operation
- Index = vpn[log2(SETS)-1:0]. Tag = full VPN, ASID, G. Valid bits are held in flops; tag and data are held in flops or latch-free RAM.
- Match: valid ∧ vpn equal ∧ (G ∨ asid equal). More than one matching way is illegal; an SVA flags it.
- Arbitration: round-robin pointer rr (reset 0). The first requesting port at or after rr is granted. After a grant, rr ← grant+1 mod NR_PORTS.
- req_ready_o is one-hot on the granted port. It is all zero when fill_valid_i, flush_i or flush_busy_o is high.
- Fill: written to the index set. Way = lowest invalid way, else the set's victim pointer. The victim pointer advances mod WAYS on every fill that evicts. A fill whose VPN/ASID already hits overwrites the hitting way.
- Flush priority: flush > fill > lookup. A fill coinciding with flush_i or flush_busy_o is discarded.
- FSM with states IDLE and WALK.
  - flush_i with neither qualifier: clear all valid bits in one cycle; stay in IDLE.
  - VPN only: invalidate matching entries in the indexed set (ASID ignored), one cycle.
  - VPN+ASID: invalidate matching non-global entries in the indexed set, one cycle.
  - ASID only: enter WALK. Counter s = 0..SETS-1 invalidates non-global entries with that ASID, one set per cycle. At s = SETS-1, return to IDLE.
  - flush_i received during WALK is ignored.

## Timing
- Lookup latency is 1 cycle: accepted at edge N, resp_valid_o one-hot for that port in cycle N+1. Throughput is 1 lookup per cycle.
- A lookup accepted in cycle N with flush_i in cycle N+1: the response is still delivered, with hit computed from pre-flush state.
- A fill at edge N is visible to a lookup accepted at edge N+1.
- WALK: flush_busy_o is high for exactly SETS cycles, starting the cycle after flush_i.
- Reset values (asynchronous): all valid bits, victim pointers, rr and counters are 0. FSM is IDLE. resp_valid_o=0, resp_hit_o=0, flush_busy_o=0. Reset during WALK aborts the walk; all entries are invalid afterwards.

## Configuration
- SHARED_TLB_PERF_EN defined: hit_cnt_o/miss_cnt_o increment on each resp_valid_o with hit/miss and wrap at 2^32. Both counters clear on an unqualified flush.
- Not defined: counters are not instantiated and both outputs are tied to 0.

## Test plan
- Fill vpn=0x12345, asid=3, ppn=0xABC. Port 0 lookup same vpn/asid -> next cycle resp_hit=1, ppn=0xABC. Lookup with asid=4 -> hit=0, ppn=0.
- Ports 0 and 1 request continuously for 4 cycles -> grants alternate 0,1,0,1; each response arrives exactly 1 cycle after its grant.
- Three fills to set 5 (vpn 0x05, 0x25, 0x45, WAYS=2) -> third fill evicts vpn 0x05; 0x25 and 0x45 still hit.
- Fill asid=7 non-global and asid=7 G=1 entries, then ASID-only flush of 7 -> flush_busy_o high 32 cycles, req_ready_o=0 throughout; afterwards only the global entry hits.
- fill_valid_i and flush_i asserted in the same cycle -> fill discarded, subsequent lookup misses.
- With SHARED_TLB_PERF_EN: 3 hits + 2 misses -> hit_cnt_o=3, miss_cnt_o=2. Unqualified flush -> both 0.
